// File: rtl/ascon_mask_pkg.sv
// Shared constants, FSM state type and LFSR step for the Ascon share encoder.
package ascon_mask_pkg;
  localparam int WIDTH_SBOX  = 5;
  localparam int ZWIDTH_SBOX = 5;
  localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
  localparam logic [31:0] LFSR_ZERO_SUB = 32'h0000_0001;

  typedef enum logic {UNSEEDED, RUN} enc_state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/mask_lfsr32.sv
// Seeded 32-bit Galois LFSR (x^32 + x^22 + x^2 + x + 1) advancing STEPS steps per enable.
module mask_lfsr32
  import ascon_mask_pkg::*;
#(
  parameter int STEPS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);
  logic [31:0] nxt;

  always_comb begin
    nxt = state;
    for (int i = 0; i < STEPS; i++) begin
      nxt = lfsr_step(nxt);
    end
  end

  // The all-zero state is a fixed point, so a zero seed is substituted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_ZERO_SUB;
    end else if (load) begin
      state <= (seed == 32'h0) ? LFSR_ZERO_SUB : seed;
    end else if (advance) begin
      state <= nxt;
    end
  end
endmodule

// File: rtl/ascon_share_encoder.sv
// Splits an unmasked S-box column into two Boolean shares plus fresh DOM randomness.
// One registered valid/ready stage; seed loads take priority over data acceptance.
module ascon_share_encoder
  import ascon_mask_pkg::*;
#(
  parameter int WIDTH  = WIDTH_SBOX,
  parameter int ZWIDTH = ZWIDTH_SBOX,
  parameter int LFSR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sa,
  output logic [WIDTH-1:0]  out_sb,
  output logic [ZWIDTH-1:0] out_z,
  output logic              seeded
);
  enc_state_t        state;
  logic [LFSR_W-1:0] lfsr;
  logic [WIDTH-1:0]  mask;
  logic [ZWIDTH-1:0] zbits;
  logic              xfer;
  logic              unused_lfsr_hi;

  assign in_ready = (state == RUN) && !seed_valid && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign mask     = lfsr[WIDTH-1:0];
  assign zbits    = lfsr[WIDTH+ZWIDTH-1:WIDTH];
  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:WIDTH+ZWIDTH];

  // Advancing by the full consumed bit count guarantees no randomness bit is reused.
  mask_lfsr32 #(
    .STEPS(WIDTH + ZWIDTH)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (seed_valid),
    .seed   (seed),
    .advance(xfer),
    .state  (lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= UNSEEDED;
      seeded <= 1'b0;
    end else if (seed_valid) begin
      state  <= RUN;
      seeded <= 1'b1;
    end
  end

  // in_data is only ever stored XORed with the mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sa    <= '0;
      out_sb    <= '0;
      out_z     <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_sa    <= in_data ^ mask;
      out_sb    <= mask;
      out_z     <= zbits;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ascon_share_encoder.sv
// Randomized scoreboard bench for ascon_share_encoder against a polynomial-level LFSR model.
module tb_ascon_share_encoder;
  logic        clk = 1'b0;
  logic        rst, seed_valid, in_valid, out_ready;
  logic [31:0] seed;
  logic [4:0]  in_data;
  logic        in_ready, out_valid, seeded;
  logic [4:0]  out_sa, out_sb, out_z;

  always #5 clk = ~clk;

  ascon_share_encoder dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sa(out_sa), .out_sb(out_sb), .out_z(out_z), .seeded(seeded)
  );

  typedef struct {
    logic [4:0] sa, sb, z, data;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          done     = 0;

  bit          m_run;
  bit          m_oval;
  logic [31:0] m_lfsr;
  logic [31:0] taps;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Taps derived from the polynomial exponents (x^32 + x^22 + x^2 + x + 1).
  function automatic logic [31:0] build_taps();
    int exps[4] = '{32, 22, 2, 1};
    logic [31:0] t = 32'h0;
    foreach (exps[k]) t[exps[k]-1] = 1'b1;
    return t;
  endfunction

  function automatic logic [31:0] advance(input logic [31:0] s, input int n);
    logic [31:0] r = s;
    for (int k = 0; k < n; k++) begin
      r = (r >> 1) ^ (r[0] ? taps : 32'h0);
    end
    return r;
  endfunction

  // Apply one cycle of inputs, check combinational/registered status against the model, update it.
  task automatic drive(input bit r, input bit sv, input logic [31:0] sd,
                       input bit iv, input logic [4:0] din, input bit ordy);
    bit   exp_rdy, x;
    exp_t e;
    @(negedge clk);
    rst = r; seed_valid = sv; seed = sd; in_valid = iv; in_data = din; out_ready = ordy;
    #1;
    exp_rdy = m_run && !sv && (!m_oval || ordy);
    chk("in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_oval});
    chk("seeded", {31'h0, seeded}, {31'h0, m_run});
    if (r) begin
      m_run = 0; m_oval = 0; m_lfsr = 32'h1;
      sb_q.delete();
    end else begin
      x = iv && exp_rdy;
      if (sv) begin
        m_lfsr = (sd == 32'h0) ? 32'h1 : sd;
        m_run  = 1;
      end else if (x) begin
        e.sb   = m_lfsr[4:0];
        e.sa   = din ^ m_lfsr[4:0];
        e.z    = m_lfsr[9:5];
        e.data = din;
        sb_q.push_back(e);
        m_lfsr = advance(m_lfsr, 10);
      end
      m_oval = x ? 1'b1 : (ordy ? 1'b0 : m_oval);
    end
  endtask

  // Monitor: pops on each consumed output and checks stability while stalled.
  initial begin
    exp_t       e;
    bit         held = 0;
    logic [4:0] h_sa, h_sb, h_z;
    while (!done) begin
      @(negedge clk);
      #2;
      if (held && out_valid && !rst) begin
        chk("stall_sa", {27'h0, out_sa}, {27'h0, h_sa});
        chk("stall_sb", {27'h0, out_sb}, {27'h0, h_sb});
        chk("stall_z", {27'h0, out_z}, {27'h0, h_z});
      end
      held = out_valid && !out_ready && !rst;
      h_sa = out_sa; h_sb = out_sb; h_z = out_z;
      if (out_valid && out_ready && !rst) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 32'h1, 32'h0);
        end else begin
          e = sb_q.pop_front();
          chk("sa", {27'h0, out_sa}, {27'h0, e.sa});
          chk("sb", {27'h0, out_sb}, {27'h0, e.sb});
          chk("z", {27'h0, out_z}, {27'h0, e.z});
          chk("unmask", {27'h0, out_sa ^ out_sb}, {27'h0, e.data});
        end
      end
    end
  end

  initial begin
    taps = build_taps();
    m_run = 0; m_oval = 0; m_lfsr = 32'h1;
    rst = 1; seed_valid = 0; seed = 0; in_valid = 0; in_data = 0; out_ready = 0;
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_sa", {27'h0, out_sa}, 32'h0);
    chk("rst_z", {27'h0, out_z}, 32'h0);

    // Unseeded: nothing accepted.
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 1, 5'(i), 1);

    drive(0, 1, 32'hA5A5_A5A5, 1, 5'h1F, 0);
    drive(0, 0, 0, 1, 5'h1F, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("dir_sa", {27'h0, out_sa}, 32'h1A);
    chk("dir_sb", {27'h0, out_sb}, 32'h05);
    chk("dir_z", {27'h0, out_z}, 32'h0D);

    // Reseed with zero while the previous word is still pending.
    drive(0, 1, 32'h0, 1, 5'h00, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("reseed_hold_sa", {27'h0, out_sa}, 32'h1A);
    drive(0, 0, 0, 1, 5'h00, 1);
    drive(0, 0, 0, 0, 0, 0);
    chk("zero_seed_sa", {27'h0, out_sa}, 32'h01);
    chk("zero_seed_sb", {27'h0, out_sb}, 32'h01);
    chk("zero_seed_z", {27'h0, out_z}, 32'h00);

    // Stall then back-to-back drain.
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 5'h0A, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 0, 1, 5'($urandom_range(0, 31)), 1);

    // Reset while an output is stalled.
    drive(0, 0, 0, 1, 5'h15, 0);
    drive(1, 0, 0, 1, 5'h03, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_mid_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_mid_sa", {27'h0, out_sa}, 32'h0);
    chk("rst_mid_sb", {27'h0, out_sb}, 32'h0);
    chk("rst_mid_seeded", {31'h0, seeded}, 32'h0);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), $urandom,
            ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1);
    chk("queue_drained", sb_q.size(), 32'h0);
    done = 1;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
